// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit for the EX stage.
// MUL uses shift-add and DIV uses restoring division. Both retire one bit per clock.
// Results, the remainder and the flag are registered, and change only when the
// DONE state retires.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start with a valid func
// S_MUL  | shift-add iterations, one multiplier bit per clock
// S_DIV  | restoring iterations, one quotient bit per clock
// S_DONE | publish result/remainder/flag, pulse done, return to idle
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic [2:0]       flag
);

  localparam logic [5:0] FUNC_MUL = 6'b000010;
  localparam logic [5:0] FUNC_DIV = 6'b000001;
  localparam int         CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  localparam logic [2:0] FLAG_OK   = 3'b000;
  localparam logic [2:0] FLAG_DIV0 = 3'b010;
  localparam logic [2:0] FLAG_OVF  = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] operand_b;  // multiplicand or divisor
  logic [WIDTH-1:0] acc_hi;     // product upper half or partial remainder
  logic [WIDTH-1:0] acc_lo;     // multiplier/product low half or dividend/quotient
  logic [CW-1:0]    bit_cnt;    // down-counter, terminal count at zero
  logic             is_mul;
  logic [2:0]       flag_pend;  // flag decided at acceptance (divide-by-zero)

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_shift;

  // One iteration of shift-add and of restoring division, from the current accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    // The borrow out of this subtraction means the trial remainder is below the divisor.
    div_diff  = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, operand_b};
  end

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      operand_b <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      bit_cnt   <= '0;
      is_mul    <= 1'b0;
      flag_pend <= FLAG_OK;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      remainder <= '0;
      flag      <= FLAG_OK;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (func == FUNC_MUL || func == FUNC_DIV)) begin
            busy      <= 1'b1;
            operand_b <= data_b;
            acc_hi    <= '0;
            acc_lo    <= data_a;
            bit_cnt   <= CNT_LOAD;
            is_mul    <= (func == FUNC_MUL);
            flag_pend <= FLAG_OK;
            if (func == FUNC_MUL) begin
              state <= S_MUL;
            end else if (data_b == '0) begin
              // Skip the iterations. The quotient is 0 and the dividend is the remainder.
              acc_hi    <= data_a;
              acc_lo    <= '0;
              flag_pend <= FLAG_DIV0;
              state     <= S_DONE;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          if (bit_cnt == '0) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_DIV: begin
          if (!div_diff[WIDTH]) begin
            acc_hi <= div_diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift;
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          if (bit_cnt == '0) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        S_DONE: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          result    <= acc_lo;
          remainder <= acc_hi;
          if (is_mul) flag <= (acc_hi != '0) ? FLAG_OVF : FLAG_OK;
          else        flag <= flag_pend;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random MUL/DIV
// compared against plain 64-bit arithmetic.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [5:0] F_MUL = 6'b000010;
  localparam logic [5:0] F_DIV = 6'b000001;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [5:0]   func  = '0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         busy, done;
  logic [W-1:0] result, remainder;
  logic [2:0]   flag;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .func(func),
    .data_a(data_a), .data_b(data_b), .busy(busy), .done(done),
    .result(result), .remainder(remainder), .flag(flag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit values.
  task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] er, output logic [W-1:0] erem,
                       output logic [2:0] ef, output int elat, output int ebusy);
    logic [63:0] p;
    if (f == F_MUL) begin
      p = {32'd0, a} * {32'd0, b};
      er = p[31:0]; erem = p[63:32];
      ef = (erem != 0) ? 3'b011 : 3'b000;
      elat = W + 1; ebusy = W;
    end else if (b == 0) begin
      er = 0; erem = a; ef = 3'b010; elat = 1; ebusy = 1;
    end else begin
      er = a / b; erem = a % b; ef = 3'b000; elat = W + 1; ebusy = W;
    end
  endtask

  // Issue one request and check the latency, busy window, results and pulse width.
  // Inputs are driven and outputs sampled on the falling edge.
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er, erem;
    logic [2:0]   ef;
    int elat, ebusy, k, bc;
    model(f, a, b, er, erem, ef, elat, ebusy);
    start = 1'b1; func = f; data_a = a; data_b = b;
    @(negedge clock);
    start = 1'b0; data_a = $urandom; data_b = $urandom;
    k = 0; bc = busy ? 1 : 0;
    while (!done && k < 200) begin
      @(negedge clock);
      k++;
      if (busy) bc++;
    end
    check({tag, " latency"}, k, elat);
    check({tag, " busy_cycles"}, bc, ebusy);
    check({tag, " busy_at_done"}, busy, 0);
    check({tag, " result"}, result, er);
    check({tag, " remainder"}, remainder, erem);
    check({tag, " flag"}, flag, ef);
    @(negedge clock);
    check({tag, " done_width"}, done, 0);
    check({tag, " result_hold"}, result, er);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [5:0]   rf;
    int k, dcount;

    repeat (2) @(negedge clock);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset remainder", remainder, 0);
    check("reset flag", flag, 0);
    reset = 1'b0;
    @(negedge clock);

    run_op("mul7x6", F_MUL, 7, 6);
    run_op("mul_ovf", F_MUL, 32'hFFFF_FFFF, 2);
    run_op("div100_7", F_DIV, 100, 7);
    run_op("div_by0", F_DIV, 5, 0);
    run_op("mul_max", F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div_max1", F_DIV, 32'hFFFF_FFFF, 1);
    run_op("div_small", F_DIV, 3, 32'hFFFF_FFFF);

    // An invalid func code is ignored.
    start = 1'b1; func = 6'b000100; data_a = 9; data_b = 9;
    @(negedge clock);
    start = 1'b0;
    dcount = 0;
    repeat (5) begin
      if (done || busy) dcount++;
      @(negedge clock);
    end
    check("invalid_func ignored", dcount, 0);

    // A restart while busy is ignored, so exactly one done with the MUL result appears.
    start = 1'b1; func = F_MUL; data_a = 3; data_b = 3;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    repeat (9) begin @(negedge clock); k++; end
    start = 1'b1; func = F_DIV; data_a = 9; data_b = 3;
    @(negedge clock); k++;
    start = 1'b0;
    while (!done && k < 200) begin @(negedge clock); k++; end
    check("restart latency", k, W + 1);
    check("restart result", result, 9);
    dcount = 0;
    repeat (40) begin @(negedge clock); if (done) dcount++; end
    check("restart single_done", dcount, 0);
    run_op("div9_3", F_DIV, 9, 3);

    // Reset in the middle of an operation aborts it without a done pulse.
    start = 1'b1; func = F_DIV; data_a = 32'hFFFF_FFFF; data_b = 3;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midreset busy", busy, 0);
    check("midreset result", result, 0);
    check("midreset remainder", remainder, 0);
    check("midreset flag", flag, 0);
    @(negedge clock);
    reset = 1'b0;
    dcount = 0;
    repeat (40) begin @(negedge clock); if (done || busy) dcount++; end
    check("midreset no_done", dcount, 0);
    run_op("mul2x2", F_MUL, 2, 2);

    // Random operations. Operand widths vary so results with and without overflow both occur.
    for (int i = 0; i < 25; i++) begin
      rf = ($urandom_range(0, 1) == 0) ? F_MUL : F_DIV;
      case ($urandom_range(0, 3))
        0: ra = $urandom_range(0, 65535);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 0;
        1: rb = $urandom_range(1, 255);
        2: rb = $urandom_range(0, 65535);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rf, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
